led_rx: RTL and testbench
=========================

# led_rx

Serial pixel-stream decoder: the receive end of the single-wire LED data protocol driven by the serializer on LED_OUT. It samples an asynchronous LED data line, classifies each high pulse as a 0 or 1 bit by its width, assembles MSB-first pixel words, and hands them out over a valid/ready port. It detects the low-level reset code as end-of-frame and flags protocol errors. It serves loopback self-test and downstream-chain readback, sitting beside the serializer on the internal 44.33 MHz clock.

## Interface
- PIXEL_BITS, 24: bits per pixel word (24 or 32).
- CLK  in  1  system clock (internal oscillator).
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  decoder enable; low = synchronous flush.
- CLEAR  in  1  one-cycle pulse; clears sticky flags.
- LED_IN  in  1  asynchronous serial data line.
- BIT_THRESH  in  8  high-time threshold in CLK cycles; high_cnt > BIT_THRESH decodes as 1.
- RESET_THRESH  in  8  reset-code low time in units of 16 CLK cycles; 0 disables EOF detection.
- PIXEL_DATA  out  PIXEL_BITS  decoded pixel, first-received bit in MSB.
- PIXEL_VALID  out  1  PIXEL_DATA holds an unconsumed pixel.
- PIXEL_READY  in  1  consumer accepts the pixel when VALID&&READY.
- EOF  out  1  one-cycle pulse on reset-code detection.
- PIXEL_COUNT  out  16  completed pixels in current/last frame, saturating.
- OVERFLOW  out  1  sticky: a pixel was dropped because the output was still full.
- PARTIAL  out  1  sticky: frame ended with 1..PIXEL_BITS-1 stray bits.
- STUCK  out  1  sticky: high pulse reached 255 cycles.

## Operation
- Input path: 2-flop synchronizer (s1, s2) plus a history flop s3. rise = s2&~s3; fall = ~s2&s3.
- high_cnt (8b): loaded with 1 on rise, increments while s2 is high, saturates at 255.
- low_cnt (12b): loaded with 1 on fall, increments while s2 is low, saturates at 4095.
- FSM states: IDLE, HIGH, LOW, ERR.
  - IDLE: rise -> HIGH.
  - HIGH: fall -> decode bit -> LOW. high_cnt==255 -> ERR; set STUCK; discard partial bits.
  - LOW: rise -> HIGH. If RESET_THRESH!=0 and low_cnt=={RESET_THRESH,4'h0} -> IDLE.
    - Pulse EOF if any bit was received since the last IDLE.
    - Set PARTIAL if bit_cnt!=0. Clear shift register and bit_cnt.
  - ERR: wait for fall, then for the reset code (same compare), -> IDLE. No EOF pulse.
- Bit decode: shift {shreg, bit} in and increment bit_cnt. On bit_cnt reaching PIXEL_BITS:
  - Transfer the word to the output register; set VALID; reset bit_cnt to 0.
  - Increment PIXEL_COUNT, saturating at 16'hFFFF.
- Output buffer (single entry): a completed pixel while VALID&&!READY in the same cycle is dropped and OVERFLOW is set; the held pixel is kept. A completion in the same cycle as a handshake loads the new pixel and VALID stays high.
- PIXEL_COUNT clears to 0 on the first rise leaving IDLE. It holds its value after EOF.
- ENABLE low:
  - FSM -> IDLE; shreg, bit_cnt, high_cnt, low_cnt and PIXEL_VALID cleared.
  - Stickies and PIXEL_COUNT retained.
- CLEAR clears OVERFLOW, PARTIAL and STUCK. A set event in the same cycle wins.

## Timing
- Reset values:
  - All outputs 0; PIXEL_DATA 0.
  - FSM IDLE; s1/s2/s3 = 0.
- Latency: LED_IN falls and is first sampled at edge k. fall is seen in cycle k+2, the bit shifts at edge k+2, and PIXEL_VALID and PIXEL_DATA update at edge k+3.
- Decode ambiguity: ±1 cycle of sampling jitter on high_cnt. Pulse widths within 1 cycle of BIT_THRESH are unspecified.
- EOF rises at the edge where low_cnt equals 16*RESET_THRESH and is high for exactly one cycle.
- PIXEL_VALID falls at the edge after VALID&&READY, unless a new pixel loads on that edge.
- Synchronous RST overrides everything, including mid-pulse and mid-pixel; all outputs return to reset values on the next edge.

## Test plan
- Nominal frame (BIT_THRESH=20, RESET_THRESH=8, PIXEL_READY=1):
  - Stimulus: 2 pixels 0xA5C31E and 0x00FF81, with 0 = 14H/40L and 1 = 28H/27L, then 200 cycles low.
  - Required: two VALID pulses with exact data; EOF once at 128 low cycles; PIXEL_COUNT=2; no flags.
- Backpressure (PIXEL_READY=0):
  - Stimulus: send 3 pixels.
  - Required: first pixel held; pixels 2 and 3 dropped; OVERFLOW=1.
  - Then: assert READY, then CLEAR -> VALID drops, OVERFLOW=0.
- Partial frame:
  - Stimulus: 30 bits, then reset code.
  - Required: one pixel out, EOF pulse, PARTIAL=1, and the next frame's first pixel decodes cleanly.
- Stuck line:
  - Stimulus: LED_IN high for 300 cycles, low for 200, then a valid pixel.
  - Required: STUCK=1; no EOF for the error frame; the following pixel decodes correctly.
- Threshold edges:
  - Stimulus: high widths 18 and 23 with BIT_THRESH=20; RESET_THRESH=0 with 4000 low cycles.
  - Required: widths decode to 0 and 1 respectively; no EOF with RESET_THRESH=0.
- Flush and reset:
  - Stimulus: ENABLE low mid-pixel (12 bits in), re-enable, send a pixel; separately, RST mid-frame.
  - Required: no stale bits in the new pixel; all outputs at reset values one edge after RST.

Source files
------------

// File: rtl/led_rx_if.sv
// rtl/led_rx_if.sv - decoded pixel output port (valid/ready) of the LED stream decoder
interface led_rx_if #(
   parameter int PIXEL_BITS = 24
);
   logic [PIXEL_BITS-1:0] PIXEL_DATA;
   logic                  PIXEL_VALID;
   logic                  PIXEL_READY;

   modport master (
      output PIXEL_DATA,
      output PIXEL_VALID,
      input  PIXEL_READY
   );

   modport slave (
      input  PIXEL_DATA,
      input  PIXEL_VALID,
      output PIXEL_READY
   );
endinterface

// File: rtl/led_rx.sv
// rtl/led_rx.sv - single-wire LED pixel-stream decoder: pulse-width bit decode, word assembly, EOF and error flags
module led_rx #(
   parameter int PIXEL_BITS = 24
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ENABLE,
   input  logic        CLEAR,
   input  logic        LED_IN,
   input  logic [7:0]  BIT_THRESH,
   input  logic [7:0]  RESET_THRESH,
   led_rx_if.master    pix,
   output logic        EOF,
   output logic [15:0] PIXEL_COUNT,
   output logic        OVERFLOW,
   output logic        PARTIAL,
   output logic        STUCK
);
   localparam int CW = $clog2(PIXEL_BITS + 1);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_ERR} state_t;

   state_t                state_q, state_d;
   logic                  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [7:0]            high_cnt_q, high_cnt_d;
   logic [11:0]           low_cnt_q, low_cnt_d;
   logic [PIXEL_BITS-1:0] shreg_q, shreg_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  got_bit_q, got_bit_d;
   logic                  done_q, done_d;
   logic [PIXEL_BITS-1:0] word_q, word_d;
   logic [PIXEL_BITS-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  eof_q, eof_d;
   logic [15:0]           count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  partial_q, partial_d;
   logic                  stuck_q, stuck_d;

   logic                  rise, fall, reset_hit, bit_val;
   logic [PIXEL_BITS-1:0] shifted;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         high_cnt_q <= '0;
         low_cnt_q  <= '0;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         got_bit_q  <= 1'b0;
         done_q     <= 1'b0;
         word_q     <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         eof_q      <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         partial_q  <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         high_cnt_q <= high_cnt_d;
         low_cnt_q  <= low_cnt_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         got_bit_q  <= got_bit_d;
         done_q     <= done_d;
         word_q     <= word_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         eof_q      <= eof_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         partial_q  <= partial_d;
         stuck_q    <= stuck_d;
      end
   end

   always_comb begin
      s1_d       = LED_IN;
      s2_d       = s1_q;
      s3_d       = s2_q;
      state_d    = state_q;
      high_cnt_d = high_cnt_q;
      low_cnt_d  = low_cnt_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      got_bit_d  = got_bit_q;
      done_d     = 1'b0;
      word_d     = word_q;
      data_d     = data_q;
      valid_d    = valid_q;
      eof_d      = 1'b0;
      count_d    = count_q;
      ovf_d      = ovf_q;
      partial_d  = partial_q;
      stuck_d    = stuck_q;

      rise      = s2_q & ~s3_q;
      fall      = ~s2_q & s3_q;
      reset_hit = (RESET_THRESH != 8'd0) && (low_cnt_q == {RESET_THRESH, 4'h0});
      bit_val   = high_cnt_q > BIT_THRESH;
      shifted   = {shreg_q[PIXEL_BITS-2:0], bit_val};

      // Clears go first so a same-cycle set event below wins.
      if (CLEAR) begin
         ovf_d     = 1'b0;
         partial_d = 1'b0;
         stuck_d   = 1'b0;
      end

      if (!ENABLE) begin
         state_d    = S_IDLE;
         high_cnt_d = '0;
         low_cnt_d  = '0;
         shreg_d    = '0;
         bit_cnt_d  = '0;
         got_bit_d  = 1'b0;
         valid_d    = 1'b0;
      end else begin
         if (rise)
            high_cnt_d = 8'd1;
         else if (s2_q && high_cnt_q != 8'hFF)
            high_cnt_d = high_cnt_q + 8'd1;

         if (fall)
            low_cnt_d = 12'd1;
         else if (!s2_q && low_cnt_q != 12'hFFF)
            low_cnt_d = low_cnt_q + 12'd1;

         // Completed words arrive one cycle after the shift; a full buffer drops them.
         if (valid_q && pix.PIXEL_READY)
            valid_d = 1'b0;
         if (done_q) begin
            if (valid_q && !pix.PIXEL_READY) begin
               ovf_d = 1'b1;
            end else begin
               data_d  = word_q;
               valid_d = 1'b1;
            end
         end

         unique case (state_q)
            S_IDLE: begin
               if (rise) begin
                  state_d = S_HIGH;
                  count_d = '0;
               end
            end
            S_HIGH: begin
               if (fall) begin
                  state_d   = S_LOW;
                  got_bit_d = 1'b1;
                  if (bit_cnt_q == CW'(PIXEL_BITS - 1)) begin
                     word_d    = shifted;
                     done_d    = 1'b1;
                     shreg_d   = '0;
                     bit_cnt_d = '0;
                     if (count_q != 16'hFFFF)
                        count_d = count_q + 16'd1;
                  end else begin
                     shreg_d   = shifted;
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else if (high_cnt_q == 8'hFF) begin
                  state_d   = S_ERR;
                  stuck_d   = 1'b1;
                  shreg_d   = '0;
                  bit_cnt_d = '0;
               end
            end
            S_LOW: begin
               if (rise) begin
                  state_d = S_HIGH;
               end else if (reset_hit) begin
                  state_d   = S_IDLE;
                  eof_d     = got_bit_q;
                  if (bit_cnt_q != '0)
                     partial_d = 1'b1;
                  shreg_d   = '0;
                  bit_cnt_d = '0;
                  got_bit_d = 1'b0;
               end
            end
            S_ERR: begin
               // low_cnt is only meaningful once the stuck pulse has actually fallen.
               if (!s2_q && !fall && reset_hit) begin
                  state_d   = S_IDLE;
                  got_bit_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign pix.PIXEL_DATA  = data_q;
   assign pix.PIXEL_VALID = valid_q;
   assign EOF             = eof_q;
   assign PIXEL_COUNT     = count_q;
   assign OVERFLOW        = ovf_q;
   assign PARTIAL         = partial_q;
   assign STUCK           = stuck_q;
endmodule

// File: tb/tb_led_rx.sv
// tb/tb_led_rx.sv - self-checking bench for led_rx: frame table, randomized frames, corner-case sequences
module tb_led_rx;
   localparam int PB = 24;
   localparam int RC = 16 * 8 + 22;

   logic        clk = 1'b0;
   logic        rst, enable, clear, led_in;
   logic [7:0]  bit_thresh, reset_thresh;
   logic        eof;
   logic [15:0] pixel_count;
   logic        overflow, partial, stuck;

   led_rx_if #(.PIXEL_BITS(PB)) pix_if ();

   led_rx #(.PIXEL_BITS(PB)) dut (
      .CLK(clk), .RST(rst), .ENABLE(enable), .CLEAR(clear), .LED_IN(led_in),
      .BIT_THRESH(bit_thresh), .RESET_THRESH(reset_thresh), .pix(pix_if.master),
      .EOF(eof), .PIXEL_COUNT(pixel_count), .OVERFLOW(overflow),
      .PARTIAL(partial), .STUCK(stuck)
   );

   always #11 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   int            eof_cnt = 0;
   logic          eof_prev = 1'b0;
   logic [PB-1:0] got_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (pix_if.PIXEL_VALID && pix_if.PIXEL_READY)
            got_q.push_back(pix_if.PIXEL_DATA);
         if (eof) begin
            eof_cnt++;
            check("eof_one_cycle", {31'd0, eof_prev}, 32'd0);
         end
      end
      eof_prev = eof;
   end

   function automatic logic [31:0] pop_px();
      if (got_q.size() == 0) return 'x;
      return {{(32-PB){1'b0}}, got_q.pop_front()};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input int h0, input int h1, input int l0, input int l1);
      led_in = 1'b1;
      tick(b ? h1 : h0);
      led_in = 1'b0;
      tick(b ? l1 : l0);
   endtask

   task automatic send_bits(input logic [31:0] w, input int n, input int h0, input int h1, input int lo);
      for (int i = n - 1; i >= 0; i--)
         send_bit(w[i], h0, h1, lo, lo);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   typedef struct {
      logic [PB-1:0] word;
      int            stray;
      int            h0;
      int            h1;
      int            lo;
      logic [PB-1:0] exp_word;
      logic [15:0]   exp_count;
      logic          exp_partial;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #(22 * 150000);
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            eof0, eof_at, npix, nstray;
      logic          bq[$];
      logic [31:0]   rw, acc;
      logic [PB-1:0] exp_q[$];
      logic [PB-1:0] nom0, nom1;

      tbl[0] = '{24'hA5C31E,  0, 14, 28, 40, 24'hA5C31E, 16'd1, 1'b0};
      tbl[1] = '{24'h123456,  6, 14, 28, 20, 24'h123456, 16'd1, 1'b1};
      tbl[2] = '{24'h5AA5F0,  0, 18, 23, 12, 24'h5AA5F0, 16'd1, 1'b0};
      tbl[3] = '{24'hFFFFFF, 23, 18, 23,  6, 24'hFFFFFF, 16'd1, 1'b1};
      tbl[4] = '{24'h000001,  1,  5, 40,  9, 24'h000001, 16'd1, 1'b1};

      rst = 1'b1; enable = 1'b1; clear = 1'b0; led_in = 1'b0;
      bit_thresh = 8'd20; reset_thresh = 8'd8; pix_if.PIXEL_READY = 1'b1;
      tick(3);
      check("rst_valid", {31'd0, pix_if.PIXEL_VALID}, 32'd0);
      check("rst_data", {8'd0, pix_if.PIXEL_DATA}, 32'd0);
      check("rst_eof", {31'd0, eof}, 32'd0);
      check("rst_count", {16'd0, pixel_count}, 32'd0);
      check("rst_flags", {29'd0, overflow, partial, stuck}, 32'd0);
      rst = 1'b0;
      tick(4);

      // Nominal two-pixel frame, EOF timed from the final fall.
      nom0 = 24'hA5C31E;
      nom1 = 24'h00FF81;
      eof0 = eof_cnt;
      for (int i = PB - 1; i >= 0; i--) send_bit(nom0[i], 14, 28, 40, 27);
      for (int i = PB - 1; i >= 1; i--) send_bit(nom1[i], 14, 28, 40, 27);
      led_in = 1'b1;
      tick(28);
      led_in = 1'b0;
      eof_at = -1;
      for (int i = 1; i <= 200; i++) begin
         tick(1);
         if (eof && eof_at < 0) eof_at = i;
      end
      check("nom_px0", pop_px(), {8'd0, nom0});
      check("nom_px1", pop_px(), {8'd0, nom1});
      check("nom_eof_count", eof_cnt - eof0, 32'd1);
      check("nom_eof_time", {31'd0, (eof_at >= 128 && eof_at <= 133)}, 32'd1);
      check("nom_count", {16'd0, pixel_count}, 32'd2);
      check("nom_flags", {29'd0, overflow, partial, stuck}, 32'd0);

      // Frame table: nominal words, partial tails and threshold-edge widths.
      for (int v = 0; v < 5; v++) begin
         eof0 = eof_cnt;
         send_bits({8'd0, tbl[v].word}, PB, tbl[v].h0, tbl[v].h1, tbl[v].lo);
         send_bits(32'h2AAA_AAAA, tbl[v].stray, tbl[v].h0, tbl[v].h1, tbl[v].lo);
         led_in = 1'b0;
         tick(RC);
         check($sformatf("tbl%0d_px", v), pop_px(), {8'd0, tbl[v].exp_word});
         check($sformatf("tbl%0d_eof", v), eof_cnt - eof0, 32'd1);
         check($sformatf("tbl%0d_count", v), {16'd0, pixel_count}, {16'd0, tbl[v].exp_count});
         check($sformatf("tbl%0d_partial", v), {31'd0, partial}, {31'd0, tbl[v].exp_partial});
         pulse_clear();
      end

      // Backpressure: first pixel held, the next two dropped.
      pix_if.PIXEL_READY = 1'b0;
      got_q.delete();
      send_bits(32'h111111, PB, 14, 28, 30);
      send_bits(32'h222222, PB, 14, 28, 30);
      send_bits(32'h333333, PB, 14, 28, 30);
      tick(10);
      check("bp_valid", {31'd0, pix_if.PIXEL_VALID}, 32'd1);
      check("bp_data", {8'd0, pix_if.PIXEL_DATA}, 32'h111111);
      check("bp_overflow", {31'd0, overflow}, 32'd1);
      check("bp_count", {16'd0, pixel_count}, 32'd3);
      pix_if.PIXEL_READY = 1'b1;
      tick(2);
      check("bp_valid_drop", {31'd0, pix_if.PIXEL_VALID}, 32'd0);
      check("bp_accepted", pop_px(), 32'h111111);
      check("bp_ovf_held", {31'd0, overflow}, 32'd1);
      pulse_clear();
      check("bp_ovf_clear", {31'd0, overflow}, 32'd0);
      tick(RC);

      // Stuck line, then a clean pixel.
      eof0 = eof_cnt;
      led_in = 1'b1;
      tick(300);
      led_in = 1'b0;
      tick(200);
      check("stuck_flag", {31'd0, stuck}, 32'd1);
      check("stuck_no_eof", eof_cnt - eof0, 32'd0);
      send_bits(32'h3C5A96, PB, 14, 28, 25);
      tick(RC);
      check("stuck_next_px", pop_px(), 32'h3C5A96);
      check("stuck_next_eof", eof_cnt - eof0, 32'd1);
      pulse_clear();
      check("stuck_cleared", {31'd0, stuck}, 32'd0);

      // EOF detection disabled.
      reset_thresh = 8'd0;
      eof0 = eof_cnt;
      send_bits(32'h0F0F0F, PB, 14, 28, 25);
      tick(4000);
      check("rt0_px", pop_px(), 32'h0F0F0F);
      check("rt0_no_eof", eof_cnt - eof0, 32'd0);
      enable = 1'b0;
      tick(2);
      enable = 1'b1;
      reset_thresh = 8'd8;
      tick(2);
      check("flush_count_kept", {16'd0, pixel_count}, 32'd1);

      // Flush mid-pixel: no stale bits may leak into the next word.
      send_bits(32'hFFF, 12, 14, 28, 20);
      enable = 1'b0;
      tick(3);
      check("flush_valid", {31'd0, pix_if.PIXEL_VALID}, 32'd0);
      enable = 1'b1;
      tick(2);
      send_bits(32'h000F0F, PB, 14, 28, 20);
      tick(RC);
      check("flush_px", pop_px(), 32'h000F0F);
      check("flush_partial", {31'd0, partial}, 32'd0);

      // Randomized frames against a bit-list reference model.
      for (int f = 0; f < 12; f++) begin
         bq.delete();
         exp_q.delete();
         npix = $urandom_range(1, 3);
         nstray = ($urandom_range(0, 2) == 0) ? $urandom_range(1, PB - 1) : 0;
         for (int p = 0; p < npix; p++) begin
            rw = $urandom;
            for (int i = PB - 1; i >= 0; i--) bq.push_back(rw[i]);
         end
         for (int i = 0; i < nstray; i++) bq.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i + PB <= bq.size(); i += PB) begin
            acc = 0;
            for (int j = 0; j < PB; j++) acc = (acc << 1) | {31'd0, bq[i + j]};
            exp_q.push_back(acc[PB-1:0]);
         end
         eof0 = eof_cnt;
         foreach (bq[i]) begin
            led_in = 1'b1;
            tick(bq[i] ? $urandom_range(23, 40) : $urandom_range(4, 17));
            led_in = 1'b0;
            tick($urandom_range(3, 20));
         end
         tick(RC);
         foreach (exp_q[i]) check($sformatf("rnd%0d_px%0d", f, i), pop_px(), {8'd0, exp_q[i]});
         check($sformatf("rnd%0d_extra", f), got_q.size(), 32'd0);
         check($sformatf("rnd%0d_count", f), {16'd0, pixel_count}, bq.size() / PB);
         check($sformatf("rnd%0d_partial", f), {31'd0, partial}, {31'd0, (bq.size() % PB) != 0});
         check($sformatf("rnd%0d_eof", f), eof_cnt - eof0, 32'd1);
         pulse_clear();
         got_q.delete();
      end

      // Synchronous reset in the middle of a pulse and a pixel.
      send_bits(32'h155, 10, 14, 28, 20);
      led_in = 1'b1;
      tick(5);
      rst = 1'b1;
      tick(1);
      check("mrst_valid", {31'd0, pix_if.PIXEL_VALID}, 32'd0);
      check("mrst_data", {8'd0, pix_if.PIXEL_DATA}, 32'd0);
      check("mrst_count", {16'd0, pixel_count}, 32'd0);
      check("mrst_eof_flags", {28'd0, eof, overflow, partial, stuck}, 32'd0);
      rst = 1'b0;
      led_in = 1'b0;
      tick(5);
      got_q.delete();
      send_bits(32'hC0FFEE, PB, 14, 28, 20);
      tick(RC);
      check("mrst_next_px", pop_px(), 32'hC0FFEE);
      check("mrst_next_partial", {31'd0, partial}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
